// File: rtl/spc7110_dcu_port.sv
// SNES-side data port of the SPC7110 decompression unit: FIFO of decompressed bytes, length counter, status, start pulse.
// Optional bank $50 read mirror is built when SPC7110_DCU_BA50_MIRROR_EN is defined.
module spc7110_dcu_port #(
    parameter int FIFO_AW = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       dcu_enable,
    input  logic       ba50mirror,
    input  logic [3:0] SNES_ADDR_LO,
    input  logic       SNES_RD_START,
    input  logic       SNES_RD_END,
    input  logic       SNES_WR_END,
    input  logic [7:0] SNES_DATA_IN,
    output logic [7:0] DATA_OUT,
    output logic       DATA_OUT_EN,
    output logic       dcu_start,
    input  logic [7:0] dcu_data,
    input  logic       dcu_valid,
    output logic       dcu_ready,
    output logic [1:0] fsm_state
);

    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    // Handshake: a byte moves from the decompressor on any rising edge where
    // dcu_valid and dcu_ready are both high; dcu_data must be stable while dcu_valid is high.

    logic [1:0]         state;
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic [15:0]        counter;
    logic               underflow;
    logic               started_zero;
    logic               start_pend;
    logic               rd_end_q;

    logic       port_hit;
    logic       fifo_full;
    logic       fifo_nonempty;
    logic       wr_start;
    logic       wr_cnt_lo;
    logic       wr_cnt_hi;
    logic       push;
    logic       pop_req;
    logic       pop;
    logic       empty_read;
    logic       run_done;
    logic [7:0] fifo_head;
    logic [7:0] status;
    logic [7:0] rd_data;

`ifdef SPC7110_DCU_BA50_MIRROR_EN
    assign port_hit = (dcu_enable && (SNES_ADDR_LO == 4'h0)) || ba50mirror;
`else
    logic unused_mirror;
    assign unused_mirror = ba50mirror;
    assign port_hit      = dcu_enable && (SNES_ADDR_LO == 4'h0);
`endif

    assign fifo_full     = count[FIFO_AW];
    assign fifo_nonempty = (count != '0);
    assign fifo_head     = fifo_nonempty ? mem[rd_ptr] : 8'h00;

    assign wr_start  = SNES_WR_END && dcu_enable && (SNES_ADDR_LO == 4'h6);
    assign wr_cnt_lo = SNES_WR_END && dcu_enable && (SNES_ADDR_LO == 4'h9);
    assign wr_cnt_hi = SNES_WR_END && dcu_enable && (SNES_ADDR_LO == 4'hA);

    // A start write flushes the FIFO this edge, so no byte may be accepted alongside it.
    assign dcu_ready = (state == ST_RUN) && !fifo_full && !wr_start;
    assign push      = dcu_valid && dcu_ready;

    assign pop_req    = SNES_RD_END && port_hit;
    assign pop        = pop_req && fifo_nonempty && !wr_start;
    assign empty_read = pop_req && !fifo_nonempty;

    // A zero count means 65536 only when the run began with it; a zero written mid-run ends on the next pop.
    assign run_done = pop && (state == ST_RUN) &&
                      ((counter == 16'd1) || ((counter == 16'd0) && !started_zero));

    assign status    = {state == ST_RUN, fifo_nonempty, 5'b0, underflow};
    assign dcu_start = (state == ST_START);
    assign fsm_state = state;

    always_comb begin
        rd_data = 8'h00;
        if (port_hit) begin
            rd_data = fifo_head;
        end else if (dcu_enable) begin
            case (SNES_ADDR_LO)
                4'h9:    rd_data = counter[7:0];
                4'hA:    rd_data = counter[15:8];
                4'hC:    rd_data = status;
                default: rd_data = 8'h00;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= dcu_data;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (wr_start) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Counter writes take priority over a decrement from a simultaneous pop.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            counter <= 16'h0000;
        end else if (wr_cnt_lo) begin
            counter[7:0] <= SNES_DATA_IN;
        end else if (wr_cnt_hi) begin
            counter[15:8] <= SNES_DATA_IN;
        end else if (pop) begin
            counter <= counter - 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            started_zero <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (state == ST_START) begin
                started_zero <= (counter == 16'd0);
            end else if (pop) begin
                started_zero <= 1'b0;
            end
            if (wr_start) begin
                underflow <= 1'b0;
            end else if (empty_read) begin
                underflow <= 1'b1;
            end
        end
    end

    // The start write parks the FSM in IDLE for one cycle so the pulse lands two cycles after the write.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            start_pend <= 1'b0;
        end else begin
            start_pend <= wr_start;
            if (wr_start) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE:  if (start_pend) state <= ST_START;
                    ST_START: state <= ST_RUN;
                    ST_RUN:   if (run_done) state <= ST_IDLE;
                    default:  state <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            DATA_OUT    <= 8'h00;
            DATA_OUT_EN <= 1'b0;
            rd_end_q    <= 1'b0;
        end else begin
            rd_end_q <= SNES_RD_END;
            if (SNES_RD_START) begin
                DATA_OUT    <= rd_data;
                DATA_OUT_EN <= port_hit || dcu_enable;
            end else if (rd_end_q) begin
                DATA_OUT    <= 8'h00;
                DATA_OUT_EN <= 1'b0;
            end
        end
    end

endmodule

// File: doc/spc7110_dcu_port.md
# spc7110_dcu_port

SNES-facing responder for the SPC7110 decompression unit (DCU) data port. It serves the bus cycles that the address decoder flags via `spc7110_dcu_enable` ($00-FF:$4800-480F) and `spc7110_dcu_ba50mirror` (bank $50). It buffers bytes from the decompressor core in a FIFO and returns them one per SNES read. It also maintains the 16-bit transfer length counter and the status register, and issues the start pulse that sends the decompressor its request.

## Interface
- `FIFO_AW`, default 4: FIFO address width; depth = 2**FIFO_AW bytes.
- `CLK`  in  1  system clock; all logic on the rising edge.
- `RST_N`  in  1  reset, asynchronous assert, active-low.
- `dcu_enable`  in  1  decoder hit on $4800-480F.
- `ba50mirror`  in  1  decoder hit on bank $50.
- `SNES_ADDR_LO`  in  4  `SNES_ADDR[3:0]`.
- `SNES_RD_START`  in  1  one-cycle pulse at start of an SNES read.
- `SNES_RD_END`  in  1  one-cycle pulse at end of an SNES read.
- `SNES_WR_END`  in  1  one-cycle pulse at end of an SNES write; data is stable.
- `SNES_DATA_IN`  in  8  write data.
- `DATA_OUT`  out  8  read data to the SNES bus mux.
- `DATA_OUT_EN`  out  1  this block drives the read data.
- `dcu_start`  out  1  one-cycle request pulse to the decompressor.
- `dcu_data`  in  8  decompressed byte.
- `dcu_valid`  in  1  `dcu_data` is valid.
- `dcu_ready`  out  1  FIFO accepts a byte. A transfer occurs on a cycle where `dcu_valid & dcu_ready` is high.

## Operation
- Port hit: `port_hit = (dcu_enable & SNES_ADDR_LO==0) | ba50mirror`. The mirror term is present only when the Configuration macro is defined.
- Register map, reads:
  - $4800 / port hit: FIFO head.
  - $4809: counter[7:0].
  - $480A: counter[15:8].
  - $480C: status = {run, nonempty, 5'b0, underflow}.
  - Any other offset reads 8'h00.
- Register map, writes:
  - $4806: start.
  - $4809 / $480A: load counter low / high byte.
  - All other writes are ignored.
- State machine `IDLE`→`START`→`RUN`→`IDLE`:
  - `IDLE`: `dcu_ready`=0.
  - Write to $4806 in any state: flush the FIFO, clear `underflow`, go to `START`.
  - `START`: one cycle; `dcu_start`=1; go to `RUN`.
  - `RUN`: `dcu_ready` = !full; `run` status bit =1.
  - `RUN`→`IDLE` when a pop decrements the counter from 1 to 0. Bytes still in the FIFO remain readable.
- Pop: on `SNES_RD_END` with `port_hit`, the FIFO is popped and the counter is decremented, provided the FIFO is non-empty.
- Empty pop: returns 8'h00; no pop; counter unchanged; `underflow` set (sticky).
- Counter: 16-bit, modulo arithmetic.
  - Counter = 0 at start means 65536 bytes. The run ends on the pop that wraps FFFF→0 after 65536 pops, which is tracked by a `started_zero` flag.
- Push and pop in the same cycle: both take effect; occupancy is unchanged. A push on a full FIFO is impossible because `dcu_ready`=0.
- Flush in the same cycle as a push: the flush wins and the byte is dropped. `dcu_ready` is forced to 0 in any cycle where `SNES_WR_END` addresses $4806.
- Counter write in the same cycle as a pop: the write wins.

## Timing
- Reset values:
  - Outputs: `DATA_OUT`=8'h00, `DATA_OUT_EN`=0, `dcu_start`=0, `dcu_ready`=0.
  - Internal: state `IDLE`, FIFO empty, counter 16'h0000, `underflow`=0.
- `DATA_OUT`/`DATA_OUT_EN`: registered. Valid 1 cycle after `SNES_RD_START` and held until the cycle after `SNES_RD_END`.
  - `DATA_OUT_EN` = 1 for any `dcu_enable` or `port_hit` read.
- Pop, counter decrement and `underflow` update take effect at the edge following `SNES_RD_END`.
- `dcu_start` pulses in the 2nd cycle after the $4806 `SNES_WR_END`.
- `dcu_ready` rises in the 3rd cycle after the $4806 `SNES_WR_END`, once `RUN` is entered.
- A pushed byte is visible at the FIFO head and in `nonempty` 1 cycle after the handshake.
- Reset mid-run: immediate return to reset values; no `dcu_start` is emitted.

## Configuration
- `SPC7110_DCU_BA50_MIRROR_EN` defined: bank $50 reads act exactly like $4800. They return the FIFO head and pop.
- Not defined: `ba50mirror` is ignored, and bank $50 reads leave `DATA_OUT_EN`=0 with no pop.

## Test plan
- Reset, then read $480C → 8'h00, `DATA_OUT_EN`=1, `dcu_ready`=0.
- Write $4809=03, $480A=00, $4806=xx; push A1,A2,A3.
  - Three $4800 reads → A1,A2,A3.
  - Counter reads 0; state `IDLE`; status 8'h00.
- Hold `dcu_valid` high with the SNES idle.
  - Exactly 2**FIFO_AW bytes are accepted, then `dcu_ready`=0.
  - One pop → `dcu_ready`=1 the next cycle.
- Read $4800 with the FIFO empty → 8'h00; status bit0=1; counter unchanged. A new $4806 write clears bit0.
- Assert the $4806 write and a `dcu_valid` push in the same cycle.
  - The FIFO is empty afterwards.
  - `dcu_start` fires once, 2 cycles later.
- Bank $50 read with FIFO head 5C:
  - With the macro: returns 5C and pops.
  - Without the macro: `DATA_OUT_EN`=0 and the FIFO is unchanged.
